axi3_master_wr: RTL

Parametrised AXI3 master write engine: accepts write commands and a write-data stream from the CPU side and drives the AXI3 write address (AW), write data (W) and write response (B) channels. It generalises the single-transaction write-address FSM to configurable address/data/ID widths and up to MAX_OUTSTANDING in-flight bursts. It also adds decoupled AW/W sequencing, WLAST generation, burst legality checking and response return. It sits between the CPU-side request logic and the interconnect, alongside the existing master and slave models.

---
 rtl/axi3_pkg.sv | 50 +++++
 rtl/axi3_wr_fifo.sv | 48 ++++
 rtl/axi3_master_wr.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axi3_pkg.sv
// Shared AXI3 write-engine types: burst encodings, response codes, FSM state
// enums, and the command legality check used at command acceptance.
package axi3_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    AW_IDLE  = 1'b0,
    AW_VALID = 1'b1
  } aw_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_t;

  // Only the low 12 address bits matter: alignment needs at most 7 of them
  // and a 4 KB crossing is visible as a carry out of bit 11.
  function automatic logic cmd_legal(input logic [11:0] addr_lo,
                                     input logic [3:0]  len,
                                     input logic [2:0]  size,
                                     input logic [1:0]  burst,
                                     input logic [2:0]  max_size);
    logic [11:0] mask;
    logic [12:0] bytes;
    logic [12:0] last_byte;
    mask      = 12'((13'd1 << size) - 13'd1);
    bytes     = ({9'd0, len} + 13'd1) << size;
    last_byte = {1'b0, addr_lo & ~mask} + bytes - 13'd1;
    cmd_legal = 1'b1;
    if (burst == 2'b11 || size > max_size) begin
      cmd_legal = 1'b0;
    end else if (burst == WRAP) begin
      if (!(len inside {4'd1, 4'd3, 4'd7, 4'd15})) cmd_legal = 1'b0;
      if ((addr_lo & mask) != 12'd0) cmd_legal = 1'b0;
    end else if (burst == INCR && last_byte[12]) begin
      cmd_legal = 1'b0;
    end
  endfunction

endpackage

// File: rtl/axi3_wr_fifo.sv
// Show-ahead synchronous FIFO carrying {id, len} from the AW side to the W
// sequencer; a push into a full FIFO is honoured when a pop happens alongside.
module axi3_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/axi3_master_wr.sv
// AXI3 master write engine: accepts CPU-side burst commands and a beat stream,
// drives AW/W/B with decoupled AW and W sequencing and bounded outstanding bursts.
module axi3_master_wr
  import axi3_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [ID_WIDTH-1:0]                cmd_id,
  input  logic [3:0]                         cmd_len,
  input  logic [2:0]                         cmd_size,
  input  logic [1:0]                         cmd_burst,
  output logic                               cmd_err,
  input  logic                               wdata_valid,
  output logic                               wdata_ready,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic [DATA_WIDTH/8-1:0]            wstrb,
  output logic                               rsp_valid,
  output logic [ID_WIDTH-1:0]                rsp_id,
  output logic [1:0]                         rsp_resp,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [ID_WIDTH-1:0]                AWID,
  output logic [ADDR_WIDTH-1:0]              AWADDR,
  output logic [3:0]                         AWLEN,
  output logic [2:0]                         AWSIZE,
  output logic [1:0]                         AWBURST,
  output logic                               AWVALID,
  input  logic                               AWREADY,
  output logic [ID_WIDTH-1:0]                WID,
  output logic [DATA_WIDTH-1:0]              WDATA,
  output logic [DATA_WIDTH/8-1:0]            WSTRB,
  output logic                               WLAST,
  output logic                               WVALID,
  input  logic                               WREADY,
  input  logic [ID_WIDTH-1:0]                BID,
  input  logic [1:0]                         BRESP,
  input  logic                               BVALID,
  output logic                               BREADY
);

  localparam int         OUT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int         FIFO_W   = ID_WIDTH + 4;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  aw_state_t         aw_state;
  w_state_t          w_state;
  logic              legal;
  logic              cmd_hs;
  logic              cmd_acc;
  logic              b_hs;
  logic              w_hs;
  logic              in_data;
  logic              w_bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_dout;
  logic [3:0]        w_len;
  logic [3:0]        beat_cnt;

  assign legal     = cmd_legal(cmd_addr[11:0], cmd_len, cmd_size, cmd_burst, MAX_SIZE);
  // Gated by rst so cmd_ready reads 0 while reset is held.
  assign cmd_ready = rst && (aw_state == AW_IDLE) &&
                     (outstanding < OUT_W'(MAX_OUTSTANDING)) && !fifo_full;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign cmd_acc   = cmd_hs && legal;
  assign BREADY    = (outstanding != '0);
  assign b_hs      = BVALID && BREADY;

  // An idle W side with nothing queued takes the command directly, so the
  // first beat can go out the cycle after acceptance.
  assign w_bypass  = (w_state == W_IDLE) && fifo_empty;
  assign fifo_push = cmd_acc && !w_bypass;
  assign fifo_pop  = (w_state == W_IDLE) && !fifo_empty;

  axi3_wr_fifo #(
    .WIDTH(FIFO_W),
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  ({cmd_id, cmd_len}),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_state <= AW_IDLE;
      AWVALID  <= 1'b0;
      AWID     <= '0;
      AWADDR   <= '0;
      AWLEN    <= '0;
      AWSIZE   <= '0;
      AWBURST  <= '0;
    end else begin
      case (aw_state)
        AW_IDLE: begin
          if (cmd_acc) begin
            AWID     <= cmd_id;
            AWADDR   <= cmd_addr;
            AWLEN    <= cmd_len;
            AWSIZE   <= cmd_size;
            AWBURST  <= cmd_burst;
            AWVALID  <= 1'b1;
            aw_state <= AW_VALID;
          end
        end
        AW_VALID: begin
          if (AWREADY) begin
            AWVALID  <= 1'b0;
            aw_state <= AW_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      cmd_err     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_resp    <= '0;
    end else begin
      if (cmd_acc && !b_hs)      outstanding <= outstanding + 1'b1;
      else if (b_hs && !cmd_acc) outstanding <= outstanding - 1'b1;
      cmd_err   <= cmd_hs && !legal;
      rsp_valid <= b_hs;
      if (b_hs) begin
        rsp_id   <= BID;
        rsp_resp <= BRESP;
      end
    end
  end

  assign in_data     = (w_state == W_DATA);
  assign WVALID      = in_data && wdata_valid;
  assign wdata_ready = in_data && WREADY;
  assign WDATA       = in_data ? wdata : '0;
  assign WSTRB       = in_data ? wstrb : '0;
  assign WLAST       = in_data && (beat_cnt == w_len);
  assign w_hs        = WVALID && WREADY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      WID      <= '0;
      w_len    <= '0;
      beat_cnt <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!fifo_empty) begin
            {WID, w_len} <= fifo_dout;
            beat_cnt     <= '0;
            w_state      <= W_DATA;
          end else if (cmd_acc) begin
            WID      <= cmd_id;
            w_len    <= cmd_len;
            beat_cnt <= '0;
            w_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (WLAST) w_state <= W_IDLE;
            else       beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
